// File: rtl/sender_rsa_if.sv
// Handshake and data bundle between the OT sender controller and its host.
// master drives gen/operands and reads results; slave is the sender_rsa side.
`timescale 1ns/1ps
interface sender_rsa_if #(parameter int WIDTH = 32);
  logic             gen;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] rand0;
  logic [WIDTH-1:0] rand1;
  logic [WIDTH-1:0] N;
  logic [WIDTH-1:0] priv_key;
  logic [WIDTH-1:0] msg0;
  logic [WIDTH-1:0] msg1;
  logic [WIDTH-1:0] enc0;
  logic [WIDTH-1:0] enc1;
  logic             gen_end;

  modport master (
    output gen, v, rand0, rand1, N, priv_key, msg0, msg1,
    input  enc0, enc1, gen_end
  );

  modport slave (
    input  gen, v, rand0, rand1, N, priv_key, msg0, msg1,
    output enc0, enc1, gen_end
  );
endinterface

// File: rtl/sender_rsa.sv
// Sender RSA stage of oblivious transfer: enc_i = (m_i + ((v - x_i)^d mod N)) mod N.
// Define SENDER_RSA_DUAL_EXP_EN to run both exponentiations in parallel on two rl_binary units.
`timescale 1ns/1ps

// Right-to-left binary modular exponentiation; each multiply is a bit-serial
// interleaved modular product taking WIDTH cycles, square and multiply share the pass.
module rl_binary #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] r,
  output logic             md_end
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {R_IDLE, R_MUL} rstate_t;

  rstate_t          rstate;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] p1;
  logic [WIDTH-1:0] p2;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p1_next;
  logic [WIDTH-1:0] p2_next;

  // One step of p = (2p + b_bit*a) mod n; p, a < n keeps every term below 2n.
  function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] m,
                                                input logic             b);
    logic [WIDTH:0] t;
    t = {p, 1'b0};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    if (b) begin
      t = t + {1'b0, a};
      if (t >= {1'b0, m}) t = t - {1'b0, m};
    end
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    p1_next = mod_step(p1, res, n, bb[cnt]);
    p2_next = mod_step(p2, bb, n, bb[cnt]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate <= R_IDLE;
      res    <= '0;
      bb     <= '0;
      e      <= '0;
      n      <= '0;
      p1     <= '0;
      p2     <= '0;
      cnt    <= '0;
      r      <= '0;
      md_end <= 1'b0;
    end else begin
      md_end <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (md_start) begin
            res <= WIDTH'(1);
            bb  <= base;
            e   <= exp;
            n   <= modulus;
            p1  <= '0;
            p2  <= '0;
            cnt <= CW'(WIDTH - 1);
            // x^0 = 1, and modulus >= 2 so 1 is already reduced
            if (exp == '0) begin
              r      <= WIDTH'(1);
              md_end <= 1'b1;
            end else begin
              rstate <= R_MUL;
            end
          end
        end
        R_MUL: begin
          if (cnt == '0) begin
            if (e[0]) res <= p1_next;
            bb <= p2_next;
            e  <= e >> 1;
            p1 <= '0;
            p2 <= '0;
            cnt <= CW'(WIDTH - 1);
            if (e[WIDTH-1:1] == '0) begin
              r      <= e[0] ? p1_next : res;
              md_end <= 1'b1;
              rstate <= R_IDLE;
            end
          end else begin
            p1  <= p1_next;
            p2  <= p2_next;
            cnt <= cnt - 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// state | meaning
// IDLE  | waiting for gen, operands latched on accept
// SUB0  | base0 = (v - x0) mod N, launch exponentiation   (SUB in dual build: both bases)
// EXP0  | waiting for k0 = base0^d mod N                  (EXP in dual build: both results)
// SUB1  | base1 = (v - x1) mod N, launch exponentiation
// EXP1  | waiting for k1; on completion enc0/enc1/gen_end are loaded
// ADD   | gen_end high, results valid
module sender_rsa #(parameter int WIDTH = 32) (
  input logic            clk,
  input logic            rst,
  sender_rsa_if.slave    bus
);
`ifdef SENDER_RSA_DUAL_EXP_EN
  typedef enum logic [1:0] {IDLE, SUB, EXP, ADD} state_t;
`else
  typedef enum logic [2:0] {IDLE, SUB0, EXP0, SUB1, EXP1, ADD} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] v_q;
  logic [WIDTH-1:0] x0_q;
  logic [WIDTH-1:0] x1_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] m0_q;
  logic [WIDTH-1:0] m1_q;
  logic [WIDTH-1:0] base0;
  logic [WIDTH-1:0] base1;
  logic [WIDTH-1:0] k0;
  logic [WIDTH-1:0] k1;

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] t;
    t = {1'b0, a} - {1'b0, b};
    if (a < b) t = t + {1'b0, m};
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[WIDTH-1:0];
  endfunction

`ifdef SENDER_RSA_DUAL_EXP_EN
  logic             md_start;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  logic             md_end0;
  logic             md_end1;
  logic             done0;
  logic             done1;
  logic             fin0;
  logic             fin1;
  logic [WIDTH-1:0] k0_now;
  logic [WIDTH-1:0] k1_now;

  rl_binary #(.WIDTH(WIDTH)) u_md0 (
    .clk(clk), .rst(rst), .md_start(md_start), .base(base0), .exp(d_q),
    .modulus(n_q), .r(r0), .md_end(md_end0)
  );
  rl_binary #(.WIDTH(WIDTH)) u_md1 (
    .clk(clk), .rst(rst), .md_start(md_start), .base(base1), .exp(d_q),
    .modulus(n_q), .r(r1), .md_end(md_end1)
  );

  // The two units can finish in different cycles; fold this cycle's result in
  always_comb begin
    fin0   = done0 | md_end0;
    fin1   = done1 | md_end1;
    k0_now = md_end0 ? r0 : k0;
    k1_now = md_end1 ? r1 : k1;
  end
`else
  logic             md_start;
  logic [WIDTH-1:0] md_base;
  logic [WIDTH-1:0] r;
  logic             md_end;

  assign md_base = (state == EXP1) ? base1 : base0;

  rl_binary #(.WIDTH(WIDTH)) u_md (
    .clk(clk), .rst(rst), .md_start(md_start), .base(md_base), .exp(d_q),
    .modulus(n_q), .r(r), .md_end(md_end)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      v_q         <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      n_q         <= '0;
      d_q         <= '0;
      m0_q        <= '0;
      m1_q        <= '0;
      base0       <= '0;
      base1       <= '0;
      k0          <= '0;
      k1          <= '0;
      md_start    <= 1'b0;
      bus.enc0    <= '0;
      bus.enc1    <= '0;
      bus.gen_end <= 1'b0;
`ifdef SENDER_RSA_DUAL_EXP_EN
      done0       <= 1'b0;
      done1       <= 1'b0;
`endif
    end else begin
      md_start    <= 1'b0;
      bus.gen_end <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.gen) begin
            v_q   <= bus.v;
            x0_q  <= bus.rand0;
            x1_q  <= bus.rand1;
            n_q   <= bus.N;
            d_q   <= bus.priv_key;
            m0_q  <= bus.msg0;
            m1_q  <= bus.msg1;
`ifdef SENDER_RSA_DUAL_EXP_EN
            state <= SUB;
`else
            state <= SUB0;
`endif
          end
        end
`ifdef SENDER_RSA_DUAL_EXP_EN
        SUB: begin
          base0    <= mod_sub(v_q, x0_q, n_q);
          base1    <= mod_sub(v_q, x1_q, n_q);
          done0    <= 1'b0;
          done1    <= 1'b0;
          md_start <= 1'b1;
          state    <= EXP;
        end
        EXP: begin
          if (md_end0) begin
            k0    <= r0;
            done0 <= 1'b1;
          end
          if (md_end1) begin
            k1    <= r1;
            done1 <= 1'b1;
          end
          if (fin0 && fin1) begin
            bus.enc0    <= mod_add(m0_q, k0_now, n_q);
            bus.enc1    <= mod_add(m1_q, k1_now, n_q);
            bus.gen_end <= 1'b1;
            state       <= ADD;
          end
        end
`else
        SUB0: begin
          base0    <= mod_sub(v_q, x0_q, n_q);
          md_start <= 1'b1;
          state    <= EXP0;
        end
        EXP0: begin
          if (md_end) begin
            k0    <= r;
            state <= SUB1;
          end
        end
        SUB1: begin
          base1    <= mod_sub(v_q, x1_q, n_q);
          md_start <= 1'b1;
          state    <= EXP1;
        end
        EXP1: begin
          // Results are loaded on the way into ADD so they are valid while gen_end is high
          if (md_end) begin
            k1          <= r;
            bus.enc0    <= mod_add(m0_q, k0, n_q);
            bus.enc1    <= mod_add(m1_q, r, n_q);
            bus.gen_end <= 1'b1;
            state       <= ADD;
          end
        end
`endif
        ADD: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sender_rsa.sv
// Directed bench for sender_rsa: N=143, d=103 vectors with hand-computed k/enc values.
`timescale 1ns/1ps
module tb_sender_rsa;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sender_rsa_if #(.WIDTH(W)) bus();
  sender_rsa #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic set_inputs(input logic [W-1:0] v, x0, x1, n, d, m0, m1);
    bus.v        = v;
    bus.rand0    = x0;
    bus.rand1    = x1;
    bus.N        = n;
    bus.priv_key = d;
    bus.msg0     = m0;
    bus.msg1     = m1;
  endtask

  // Pulse gen, then count gen_end pulses until 20 cycles past the first one (bounded).
  task automatic run(output int pulses, output int latency);
    @(negedge clk); bus.gen = 1'b1;
    @(negedge clk); bus.gen = 1'b0;
    pulses  = 0;
    latency = -1;
    for (int i = 1; i < 4000; i++) begin
      if (bus.gen_end) begin
        pulses++;
        if (latency < 0) latency = i;
      end
      if (latency >= 0 && i > latency + 20) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 0);
    bus.gen = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.enc0 !== 32'd0) begin n_fail++; $display("FAIL reset_enc0 got %0d want 0", bus.enc0); end
    n_tests++; if (bus.enc1 !== 32'd0) begin n_fail++; $display("FAIL reset_enc1 got %0d want 0", bus.enc1); end
    n_tests++; if (bus.gen_end !== 1'b0) begin n_fail++; $display("FAIL reset_gen_end got %0b want 0", bus.gen_end); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int p, lat;
    set_inputs(97, 20, 50, 143, 103, 30, 40);
    run(p, lat);
    n_tests++; if (p !== 1) begin n_fail++; $display("FAIL basic_pulses got %0d want 1", p); end
    n_tests++; if (bus.enc0 !== 32'd107) begin n_fail++; $display("FAIL basic_enc0 got %0d want 107", bus.enc0); end
    n_tests++; if (bus.enc1 !== 32'd45) begin n_fail++; $display("FAIL basic_enc1 got %0d want 45", bus.enc1); end
`ifdef SENDER_RSA_DUAL_EXP_EN
    n_tests++; if (!(lat > 0 && lat < 300)) begin n_fail++; $display("FAIL dual_latency got %0d want 1..299", lat); end
`else
    n_tests++; if (!(lat > 400)) begin n_fail++; $display("FAIL single_latency got %0d want >400", lat); end
`endif
  endtask

  task automatic test_add_wrap();
    int p, lat;
    set_inputs(97, 20, 50, 143, 103, 100, 40);
    run(p, lat);
    n_tests++; if (p !== 1) begin n_fail++; $display("FAIL wrap_pulses got %0d want 1", p); end
    n_tests++; if (bus.enc0 !== 32'd34) begin n_fail++; $display("FAIL wrap_enc0 got %0d want 34", bus.enc0); end
    n_tests++; if (bus.enc1 !== 32'd45) begin n_fail++; $display("FAIL wrap_enc1 got %0d want 45", bus.enc1); end
  endtask

  task automatic test_add_zero();
    int p, lat;
    // 66+77 = 143 and 138+5 = 143 both land exactly on N
    set_inputs(97, 20, 50, 143, 103, 66, 138);
    run(p, lat);
    n_tests++; if (p !== 1) begin n_fail++; $display("FAIL zero_pulses got %0d want 1", p); end
    n_tests++; if (bus.enc0 !== 32'd0) begin n_fail++; $display("FAIL zero_enc0 got %0d want 0", bus.enc0); end
    n_tests++; if (bus.enc1 !== 32'd0) begin n_fail++; $display("FAIL zero_enc1 got %0d want 0", bus.enc1); end
  endtask

  task automatic test_sub_wrap();
    int p, lat;
    // base0 = 133 -> k0 = 133, enc0 = 138; base1 = 0 -> k1 = 0, enc1 = 7
    set_inputs(10, 20, 10, 143, 103, 5, 7);
    run(p, lat);
    n_tests++; if (p !== 1) begin n_fail++; $display("FAIL subwrap_pulses got %0d want 1", p); end
    n_tests++; if (bus.enc0 !== 32'd138) begin n_fail++; $display("FAIL subwrap_enc0 got %0d want 138", bus.enc0); end
    n_tests++; if (bus.enc1 !== 32'd7) begin n_fail++; $display("FAIL subwrap_enc1 got %0d want 7", bus.enc1); end
  endtask

  task automatic test_reset_abort();
    int p, lat, seen;
    set_inputs(97, 20, 50, 143, 103, 30, 40);
    @(negedge clk); bus.gen = 1'b1;
    @(negedge clk); bus.gen = 1'b0;
    repeat (60) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bus.enc0 !== 32'd0) begin n_fail++; $display("FAIL abort_enc0 got %0d want 0", bus.enc0); end
    n_tests++; if (bus.enc1 !== 32'd0) begin n_fail++; $display("FAIL abort_enc1 got %0d want 0", bus.enc1); end
    n_tests++; if (bus.gen_end !== 1'b0) begin n_fail++; $display("FAIL abort_gen_end got %0b want 0", bus.gen_end); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (bus.gen_end) seen++; end
    rst = 1'b0;
    repeat (600) begin @(negedge clk); if (bus.gen_end) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_gen_end got %0d pulses want 0", seen); end
    run(p, lat);
    n_tests++; if (p !== 1) begin n_fail++; $display("FAIL rerun_pulses got %0d want 1", p); end
    n_tests++; if (bus.enc0 !== 32'd107) begin n_fail++; $display("FAIL rerun_enc0 got %0d want 107", bus.enc0); end
    n_tests++; if (bus.enc1 !== 32'd45) begin n_fail++; $display("FAIL rerun_enc1 got %0d want 45", bus.enc1); end
  endtask

  task automatic test_ignore();
    int seen, i;
    set_inputs(97, 20, 50, 143, 103, 100, 40);
    @(negedge clk); bus.gen = 1'b1;
    @(negedge clk); bus.gen = 1'b0;
    set_inputs(1, 2, 3, 143, 7, 4, 5);
    seen = 0;
    for (i = 0; i < 3000; i++) begin
      bus.gen = 1'b0;
      if (bus.gen_end) break;
      if (i % 37 == 36) bus.gen = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (bus.gen_end !== 1'b1) begin n_fail++; $display("FAIL ignore_gen_end got %0b want 1", bus.gen_end); end
    n_tests++; if (bus.enc0 !== 32'd34) begin n_fail++; $display("FAIL ignore_enc0 got %0d want 34", bus.enc0); end
    n_tests++; if (bus.enc1 !== 32'd45) begin n_fail++; $display("FAIL ignore_enc1 got %0d want 45", bus.enc1); end
    // gen coinciding with gen_end must not start a run
    bus.gen = 1'b1;
    @(negedge clk); bus.gen = 1'b0;
    repeat (800) begin @(negedge clk); if (bus.gen_end) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL same_cycle_gen got %0d pulses want 0", seen); end
    n_tests++; if (bus.enc0 !== 32'd34) begin n_fail++; $display("FAIL hold_enc0 got %0d want 34", bus.enc0); end
  endtask

  task automatic test_back_to_back();
    int i, p, lat;
    set_inputs(97, 20, 50, 143, 103, 30, 40);
    @(negedge clk); bus.gen = 1'b1;
    @(negedge clk); bus.gen = 1'b0;
    for (i = 0; i < 3000; i++) begin
      if (bus.gen_end) break;
      @(negedge clk);
    end
    n_tests++; if (bus.gen_end !== 1'b1) begin n_fail++; $display("FAIL b2b_first_gen_end got %0b want 1", bus.gen_end); end
    n_tests++; if (bus.enc0 !== 32'd107) begin n_fail++; $display("FAIL b2b_first_enc0 got %0d want 107", bus.enc0); end
    set_inputs(10, 20, 10, 143, 103, 5, 7);
    run(p, lat);
    n_tests++; if (p !== 1) begin n_fail++; $display("FAIL b2b_second_pulses got %0d want 1", p); end
    n_tests++; if (bus.enc0 !== 32'd138) begin n_fail++; $display("FAIL b2b_second_enc0 got %0d want 138", bus.enc0); end
    n_tests++; if (bus.enc1 !== 32'd7) begin n_fail++; $display("FAIL b2b_second_enc1 got %0d want 7", bus.enc1); end
  endtask

  initial begin
    bus.gen = 1'b0;
    test_reset();
    test_basic();
    test_add_wrap();
    test_add_zero();
    test_sub_wrap();
    test_reset_abort();
    test_ignore();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
